// File: rtl/peripheral_bus_pkg.sv
// Shared definitions for the memory-mapped peripheral window.
// Provides the default base address and window size, register word offsets,
// TCON bit positions and the LED / seven-segment register widths.
package peripheral_bus_pkg;

    localparam logic [31:0] BASE_ADDR_DEFAULT    = 32'h4000_0000;
    localparam int unsigned WINDOW_WORDS_DEFAULT = 6;

    // Word offsets (byte offset / 4) of each register inside the window.
    typedef enum logic [2:0] {
        RegTh      = 3'd0,
        RegTl      = 3'd1,
        RegTcon    = 3'd2,
        RegLed     = 3'd3,
        RegDigi    = 3'd4,
        RegSystick = 3'd5
    } reg_word_e;

    // TCON bit indices.
    localparam int unsigned TCON_EN = 0;
    localparam int unsigned TCON_IE = 1;
    localparam int unsigned TCON_IF = 2;
    localparam int unsigned TCON_W  = 3;

    localparam int unsigned LED_W  = 8;
    localparam int unsigned DIGI_W = 12;

    // Word offset of a register widened to the decoder's offset width.
    function automatic logic [29:0] word_of(input reg_word_e r);
        return {27'd0, r};
    endfunction

endpackage

// File: rtl/periph_timer.sv
// Reloading 32-bit timer owning TH, TL and TCON.
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   th_we/tl_we/tcon_we  CPU write strobes (already address-decoded)
//   wdata             CPU store data
//   th, tl, tcon      registered values for the read mux
//   irq               level interrupt, IF & IE
// TL counts up while EN=1; on the edge after TL=FFFF_FFFF it reloads from TH
// and sets IF if IE=1. CPU writes take priority over the hardware update.
module periph_timer
    import peripheral_bus_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              th_we,
    input  logic              tl_we,
    input  logic              tcon_we,
    input  logic [31:0]       wdata,
    output logic [31:0]       th,
    output logic [31:0]       tl,
    output logic [TCON_W-1:0] tcon,
    output logic              irq
);

    logic [31:0]       th_q, th_d;
    logic [31:0]       tl_q, tl_d;
    logic [TCON_W-1:0] tcon_q, tcon_d;
    logic              en;
    logic              wrap;

    assign en   = tcon_q[TCON_EN];
    assign wrap = (tl_q == 32'hFFFF_FFFF);

    always_comb begin
        th_d = th_q;
        if (th_we) begin
            th_d = wdata;
        end
    end

    // Reload uses th_q, so a TH write in the reload cycle only affects the
    // following reload.
    always_comb begin
        tl_d = tl_q;
        if (en) begin
            tl_d = wrap ? th_q : tl_q + 32'd1;
        end
        if (tl_we) begin
            tl_d = wdata;
        end
    end

    // A CPU write replaces all three bits, including a same-cycle IF set.
    always_comb begin
        tcon_d = tcon_q;
        if (en && wrap && tcon_q[TCON_IE]) begin
            tcon_d[TCON_IF] = 1'b1;
        end
        if (tcon_we) begin
            tcon_d = wdata[TCON_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            th_q   <= '0;
            tl_q   <= '0;
            tcon_q <= '0;
        end else begin
            th_q   <= th_d;
            tl_q   <= tl_d;
            tcon_q <= tcon_d;
        end
    end

    assign th   = th_q;
    assign tl   = tl_q;
    assign tcon = tcon_q;
    assign irq  = tcon_q[TCON_IF] & tcon_q[TCON_IE];

endmodule

// File: rtl/peripheral_bus.sv
// CPU-facing peripheral window: address decode, LED and seven-segment
// registers, free-running SYSTICK counter, timer instance and read mux.
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   MemRead, MemWrite   CPU load / store strobes
//   Address             CPU byte address (bits [1:0] ignored)
//   Write_data          CPU store data
//   Read_data           combinational load data (0 unless a read hit)
//   IRQ                 timer interrupt, level
//   led, digi           LED and seven-segment register contents
// Read_data depends only on registered state, never on Write_data, so a
// simultaneous read and write returns the pre-write value.
module peripheral_bus
    import peripheral_bus_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = BASE_ADDR_DEFAULT,
    parameter int unsigned WINDOW_WORDS = WINDOW_WORDS_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [31:0]       Address,
    input  logic [31:0]       Write_data,
    output logic [31:0]       Read_data,
    output logic              IRQ,
    output logic [LED_W-1:0]  led,
    output logic [DIGI_W-1:0] digi
);

    logic [29:0]       word_off;
    logic              hit;
    logic              wr_hit;
    logic              th_we, tl_we, tcon_we, led_we, digi_we;
    logic [31:0]       th, tl;
    logic [TCON_W-1:0] tcon;
    logic [LED_W-1:0]  led_q;
    logic [DIGI_W-1:0] digi_q;
    logic [31:0]       systick_q;
    logic              unused_addr_lsb;

    assign unused_addr_lsb = ^Address[1:0];

    // Addresses below the base wrap to huge offsets and miss the window.
    assign word_off = Address[31:2] - BASE_ADDR[31:2];
    assign hit      = ({2'b00, word_off} < WINDOW_WORDS);
    assign wr_hit   = MemWrite && hit;

    assign th_we   = wr_hit && (word_off == word_of(RegTh));
    assign tl_we   = wr_hit && (word_off == word_of(RegTl));
    assign tcon_we = wr_hit && (word_off == word_of(RegTcon));
    assign led_we  = wr_hit && (word_off == word_of(RegLed));
    assign digi_we = wr_hit && (word_off == word_of(RegDigi));

    periph_timer u_timer (
        .clk     (clk),
        .reset   (reset),
        .th_we   (th_we),
        .tl_we   (tl_we),
        .tcon_we (tcon_we),
        .wdata   (Write_data),
        .th      (th),
        .tl      (tl),
        .tcon    (tcon),
        .irq     (IRQ)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led_q     <= '0;
            digi_q    <= '0;
            systick_q <= '0;
        end else begin
            if (led_we) begin
                led_q <= Write_data[LED_W-1:0];
            end
            if (digi_we) begin
                digi_q <= Write_data[DIGI_W-1:0];
            end
            systick_q <= systick_q + 32'd1;
        end
    end

    always_comb begin
        Read_data = '0;
        if (MemRead && hit) begin
            case (word_off)
                word_of(RegTh):      Read_data = th;
                word_of(RegTl):      Read_data = tl;
                word_of(RegTcon):    Read_data = 32'(tcon);
                word_of(RegLed):     Read_data = 32'(led_q);
                word_of(RegDigi):    Read_data = 32'(digi_q);
                word_of(RegSystick): Read_data = systick_q;
                default:             Read_data = '0;
            endcase
        end
    end

    assign led  = led_q;
    assign digi = digi_q;

endmodule

// File: tb/tb_peripheral_bus.sv
`timescale 1ns / 100ps
module tb_peripheral_bus;

    localparam logic [31:0] BASE = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead, MemWrite;
    logic [31:0] Address, Write_data;
    logic [31:0] Read_data;
    logic        IRQ;
    logic [7:0]  led;
    logic [11:0] digi;

    peripheral_bus #(
        .BASE_ADDR    (BASE),
        .WINDOW_WORDS (6)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .Address    (Address),
        .Write_data (Write_data),
        .Read_data  (Read_data),
        .IRQ        (IRQ),
        .led        (led),
        .digi       (digi)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rd;
        logic        irq;
        logic [7:0]  led;
        logic [11:0] digi;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    // Reference model: architectural register contents after the last edge.
    logic [31:0] m_th, m_tl, m_systick;
    logic        m_en, m_ie, m_if;
    logic [7:0]  m_led;
    logic [11:0] m_digi;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic int addr_index(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        if (a >= BASE && off < 32'd24) return int'(off >> 2);
        return -1;
    endfunction

    function automatic logic [31:0] model_read(input int idx);
        case (idx)
            0:       return m_th;
            1:       return m_tl;
            2:       return {29'd0, m_if, m_ie, m_en};
            3:       return {24'd0, m_led};
            4:       return {20'd0, m_digi};
            5:       return m_systick;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_th = 0; m_tl = 0; m_systick = 0;
        m_en = 0; m_ie = 0; m_if = 0;
        m_led = 0; m_digi = 0;
    endtask

    // Effect of one rising edge given the inputs present during that cycle.
    task automatic model_edge(input logic wr, input int idx, input logic [31:0] d);
        logic [31:0] n_th, n_tl;
        logic        n_en, n_ie, n_if;
        n_th = m_th; n_tl = m_tl; n_en = m_en; n_ie = m_ie; n_if = m_if;
        if (m_en) begin
            if (m_tl == 32'hFFFF_FFFF) begin
                n_tl = m_th;
                if (m_ie) n_if = 1'b1;
            end else begin
                n_tl = m_tl + 32'd1;
            end
        end
        if (wr) begin
            case (idx)
                0: n_th = d;
                1: n_tl = d;
                2: begin n_en = d[0]; n_ie = d[1]; n_if = d[2]; end
                3: m_led = d[7:0];
                4: m_digi = d[11:0];
                default: ;
            endcase
        end
        m_th = n_th; m_tl = n_tl; m_en = n_en; m_ie = n_ie; m_if = n_if;
        m_systick = m_systick + 32'd1;
    endtask

    // Drive one bus cycle, queue the expected outputs, advance the model.
    task automatic cycle(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d);
        exp_t e;
        int   idx;
        @(posedge clk);
        #1;
        MemRead = rd; MemWrite = wr; Address = a; Write_data = d;
        idx  = addr_index(a);
        e.rd = (rd && idx >= 0) ? model_read(idx) : 32'd0;
        e.irq  = m_if & m_ie;
        e.led  = m_led;
        e.digi = m_digi;
        exp_q.push_back(e);
        model_edge(wr, idx, d);
    endtask

    // Pulse reset for 3 ns between edges and check the asynchronous clear.
    task automatic do_reset();
        @(posedge clk);
        #2;
        MemRead = 1'b1; MemWrite = 1'b0; Address = BASE + 32'h4; Write_data = 32'd0;
        #4;
        reset = 1'b0;
        #1;
        check("rst_read_tl", Read_data, 32'd0);
        check("rst_irq", 32'(IRQ), 32'd0);
        check("rst_led", 32'(led), 32'd0);
        check("rst_digi", 32'(digi), 32'd0);
        #2;
        reset = 1'b1;
        Address = BASE + 32'h14;
        #0.5;
        check("systick_before_edge", Read_data, 32'd0);
        MemRead = 1'b0;
        model_reset();
        model_edge(1'b0, -1, 32'd0);
    endtask

    // Scoreboard monitor: one expectation per driven cycle, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("read_data", Read_data, e.rd);
                check("irq", 32'(IRQ), 32'(e.irq));
                check("led", 32'(led), 32'(e.led));
                check("digi", 32'(digi), 32'(e.digi));
            end
        end
    end

    initial begin
        int guard;
        reset = 1'b1;
        MemRead = 0; MemWrite = 0; Address = 0; Write_data = 0;
        model_reset();
        #1 reset = 1'b0;
        do_reset();

        // SYSTICK after 10 edges, unmapped read, read without MemRead.
        repeat (9) cycle(0, 0, BASE + 32'h14, 0);
        cycle(1, 0, BASE + 32'h14, 0);
        cycle(1, 0, BASE + 32'h18, 0);
        cycle(0, 0, BASE + 32'h14, 0);

        // Overflow / reload sequence.
        cycle(0, 1, BASE + 32'h0, 32'hFFFF_FFFC);
        cycle(0, 1, BASE + 32'h4, 32'hFFFF_FFFE);
        cycle(0, 1, BASE + 32'h8, 32'd3);
        repeat (10) cycle(1, 0, BASE + 32'h4, 0);
        cycle(1, 0, BASE + 32'h8, 0);

        // Clear IF by writing TCON=3, then write TCON=1 on an overflow cycle.
        cycle(0, 1, BASE + 32'h8, 32'd3);
        cycle(1, 0, BASE + 32'h8, 0);
        guard = 0;
        while (m_tl != 32'hFFFF_FFFF && guard < 16) begin
            cycle(1, 0, BASE + 32'h4, 0);
            guard++;
        end
        check("reached_overflow", 32'(guard < 16), 32'd1);
        cycle(0, 1, BASE + 32'h8, 32'd1);
        cycle(1, 0, BASE + 32'h8, 0);
        cycle(1, 0, BASE + 32'h4, 0);

        // CPU write of TL collides with an increment.
        cycle(0, 1, BASE + 32'h4, 32'h55);
        cycle(1, 0, BASE + 32'h4, 0);
        cycle(1, 0, BASE + 32'h4, 0);

        // LED/DIGI truncation, ignored SYSTICK write, read-during-write.
        cycle(0, 1, BASE + 32'hC, 32'h1FF);
        cycle(0, 1, BASE + 32'h10, 32'hABCD);
        cycle(0, 1, BASE + 32'h14, 32'd0);
        cycle(1, 0, BASE + 32'h14, 0);
        cycle(1, 1, BASE + 32'hC, 32'h5A);
        cycle(1, 0, BASE + 32'hC, 0);

        // Raise IRQ while counting, then reset mid-cycle.
        cycle(0, 1, BASE + 32'h0, 32'hFFFF_FFF0);
        cycle(0, 1, BASE + 32'h4, 32'hFFFF_FFFE);
        cycle(0, 1, BASE + 32'h8, 32'd3);
        repeat (4) cycle(1, 0, BASE + 32'h8, 0);
        check("irq_before_reset", 32'(m_if & m_ie), 32'd1);
        do_reset();
        repeat (5) cycle(1, 0, BASE + 32'h8, 0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            logic        rd, wr;
            logic [31:0] a, d;
            int          r;
            rd = ($urandom_range(0, 3) != 0);
            wr = ($urandom_range(0, 9) < 3);
            r  = int'($urandom_range(0, 9));
            case (r)
                6:       a = BASE + 32'h18;
                7:       a = BASE - 32'h4;
                8:       a = $urandom;
                9:       a = BASE + 32'(4 * $urandom_range(0, 5));
                default: a = BASE + 32'(4 * r) + 32'($urandom_range(0, 3));
            endcase
            if (addr_index(a) == 2) d = 32'($urandom_range(0, 7)) | ($urandom & 32'hFFFF_FFF8);
            else if ($urandom_range(0, 1) == 1) d = 32'hFFFF_FFFF - 32'($urandom_range(0, 6));
            else d = $urandom;
            cycle(rd, wr, a, d);
        end

        @(posedge clk);
        #1;
        MemRead = 0; MemWrite = 0;
        @(negedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/peripheral_bus.md
PERIPHERAL_BUS -- requirements
Module: peripheral_bus

Interface
REQ-001 Parameter: BASE_ADDR, 32'h4000_0000, base byte address of the peripheral window.
REQ-002 Parameter: WINDOW_WORDS, 6, number of mapped 32-bit registers; all other addresses are unmapped.
REQ-003 Clocking: one clock; reset is asynchronous and active-low.
REQ-004 Port clk, input, 1, system clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1, asynchronous active-low reset.
REQ-006 Port MemRead, input, 1, CPU load strobe.
REQ-007 Port MemWrite, input, 1, CPU store strobe.
REQ-008 Port Address, input, 32, CPU byte address; bits [1:0] ignored.
REQ-009 Port Write_data, input, 32, CPU store data.
REQ-010 Port Read_data, output, 32, load data returned to the CPU.
REQ-011 Port IRQ, output, 1, timer interrupt request, level.
REQ-012 Port led, output, 8, LED register contents.
REQ-013 Port digi, output, 12, seven-segment register contents.

Function
REQ-014 Address map, offsets from BASE_ADDR: 0x00 TH (RW), 0x04 TL (RW), 0x08 TCON (RW, bits [2:0]), 0x0C LED (RW, [7:0]), 0x10 DIGI (RW, [11:0]), 0x14 SYSTICK (RO).
REQ-015 Hit: Address[31:2] matches one mapped word; out-of-window accesses are not hits.
REQ-016 Reads: Read_data is combinational, same cycle, and equals the register zero-extended when MemRead=1 and the access is a hit; otherwise Read_data is 0.
REQ-017 Writes: a register updates on the rising edge where MemWrite=1 and the access is a hit; unused upper bits are discarded; writes to SYSTICK and unmapped addresses are ignored.
REQ-018 TCON bits: [0] EN (timer enable), [1] IE (interrupt enable), [2] IF (interrupt flag); bits [31:3] read as 0.
REQ-019 Timer, EN=1: TL increments by 1 each cycle.
REQ-020 Timer overflow: when EN=1 and TL=32'hFFFF_FFFF, the next edge loads TL<=TH instead of incrementing; IF<=1 on the same edge if IE=1.
REQ-021 Timer, EN=0: TL holds; IF holds.
REQ-022 IRQ = IF & IE, combinational from registered bits.
REQ-023 IF is cleared only by a CPU write of 0 to TCON[2]; a CPU write of 1 to TCON[2] sets it.
REQ-024 Simultaneous CPU write to TL and timer increment/reload: the CPU write wins.
REQ-025 Simultaneous CPU write to TCON and hardware IF set: the CPU-written value wins for all three bits.
REQ-026 CPU write to TH during a reload cycle: the reload uses the old TH; the new TH applies from the next reload.
REQ-027 SYSTICK increments by 1 every cycle unconditionally and wraps 32'hFFFF_FFFF -> 0.
REQ-028 MemRead and MemWrite both 1 in one cycle: the read returns the pre-write value and the write takes effect at the edge.

Reset
REQ-029 While reset=0: TH, TL, TCON, LED, DIGI and SYSTICK are 0, so IRQ=0, led=0 and digi=0; Read_data follows REQ-016 with zeroed registers.
REQ-030 Reset assertion mid-count clears all state immediately, without waiting for clk.
REQ-031 After deassertion: SYSTICK reads 0 before the first edge, 1 after it; the timer stays idle until EN is written.

Structure
REQ-032 Shared package: BASE_ADDR default, register word offsets, TCON bit indices (EN/IE/IF), LED and DIGI widths.
REQ-033 One sub-module, periph_timer: owns TH/TL/TCON and exposes write strobes, read values and IRQ; peripheral_bus owns decode, LED, DIGI, SYSTICK and the read mux.
REQ-034 No combinational path from Write_data to Read_data; reads see registered state only.

Verification
REQ-035 Reset, then read SYSTICK after 10 edges -> Read_data=10; read unmapped 0x4000_0018 -> 0; read with MemRead=0 -> 0.
REQ-036 Write TH=0xFFFF_FFFC, TL=0xFFFF_FFFE, TCON=3 -> TL goes FFFF_FFFF, then FFFF_FFFC with IF=1 and IRQ=1 on that edge; afterwards TL counts FFFF_FFFD, FFFF_FFFE, FFFF_FFFF, then reloads FFFF_FFFC again.
REQ-037 With IF=1 write TCON=3 -> IF=0, IRQ=0 next cycle; write TCON=1 on an overflow cycle -> IF stays 0 and IRQ=0.
REQ-038 Write TL=0x55 in the same cycle the timer would increment it -> TL reads 0x55, then 0x56.
REQ-039 Write LED=0x1FF, DIGI=0xABCD -> led=0xFF, digi=0xBCD; a write to SYSTICK is ignored and the count continues.
REQ-040 Assert reset for 3 ns between clock edges while TL counts -> all outputs 0 immediately; no IRQ after release.
